// File: rtl/store_unit.sv
// store_unit: posted-write buffer that drains {addr, data} entries to memory one write at a time
// Ports:
//    clk, rst (async, active-low), ce (clock enable; 0 freezes all state)
//    store_req/addr_in/data_UAL : 1-cycle write request into the FIFO
//    mem_ready                  : memory accepts the current write
//    data_mem/addr_mem/we_mem   : registered write port toward memory
//    full/busy                  : buffer status
//    done                       : 1-cycle pulse per completed write
//    ovf/err                    : sticky drop / timeout flags
module store_unit #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 6,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              store_req,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_UAL,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] data_mem,
   output logic [ADDR_W-1:0] addr_mem,
   output logic              we_mem,
   output logic              full,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic              err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t            state_q;
   logic [ADDR_W-1:0] fifo_a [DEPTH];
   logic [DATA_W-1:0] fifo_d [DEPTH];
   logic [PW-1:0]     rd_q, wr_q;
   logic [CW-1:0]     count_q, count_d;
   logic [TW-1:0]     tmo_q;
   logic [DATA_W-1:0] data_mem_q;
   logic [ADDR_W-1:0] addr_mem_q;
   logic              we_q, done_q, ovf_q, err_q;
   logic              issuing, push, expire, pop;
   // full is taken before this cycle's pop, so a request arriving while full is dropped even if a slot frees up
   always_comb begin
      issuing = state_q == ISSUE;
      push    = store_req & ~full;
      expire  = issuing & ~mem_ready & (tmo_q == TW'(TIMEOUT - 1));
      pop     = issuing & (mem_ready | expire);
      count_d = count_q + CW'(push) - CW'(pop);
   end
   // Storage needs no reset: an entry is only read while count is non-zero
   always_ff @(posedge clk) begin
      if (ce && push) begin
         fifo_a[wr_q] <= addr_in;
         fifo_d[wr_q] <= data_UAL;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         tmo_q      <= '0;
         data_mem_q <= '0;
         addr_mem_q <= '0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else if (ce) begin
         if (push) wr_q <= wr_q + PW'(1);
         if (pop) rd_q <= rd_q + PW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_q | (store_req & full);
         err_q   <= err_q | expire;
         done_q  <= issuing & mem_ready;
         if (!issuing) begin
            // The head is latched here and held for the whole write, so pushes cannot disturb it
            if (count_q != '0) begin
               state_q    <= ISSUE;
               tmo_q      <= '0;
               we_q       <= 1'b1;
               addr_mem_q <= fifo_a[rd_q];
               data_mem_q <= fifo_d[rd_q];
            end
         end else if (pop) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
         end else begin
            tmo_q <= tmo_q + TW'(1);
         end
      end
   end
   assign data_mem = data_mem_q;
   assign addr_mem = addr_mem_q;
   assign we_mem   = we_q;
   assign done     = done_q;
   assign ovf      = ovf_q;
   assign err      = err_q;
   assign full     = count_q == CW'(DEPTH);
   assign busy     = (count_q != '0) | issuing;
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameters: DATA_W default 16, memory data width; ADDR_W default 6, memory address width; DEPTH default 2, posted-write buffer entries (power of 2, at least 2); TIMEOUT default 15, maximum ISSUE cycles waiting for mem_ready (at least 1).
REQ-002 Ports, clock and reset first, SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets the block.
- ce  in  1  clock enable; 0 freezes all state.
- store_req  in  1  request to write data_UAL to addr_in, 1-cycle qualifier.
- addr_in  in  ADDR_W  target address.
- data_UAL  in  DATA_W  ALU/accumulator value to store.
- mem_ready  in  1  memory accepts the current write this cycle.
- data_mem  out  DATA_W  write data to memory.
- addr_mem  out  ADDR_W  write address to memory.
- we_mem  out  1  write strobe.
- full  out  1  buffer holds DEPTH entries.
- busy  out  1  buffer non-empty or FSM not IDLE.
- done  out  1  1-cycle pulse when a write completes.
- ovf  out  1  sticky: a request was dropped because the buffer was full.
- err  out  1  sticky: a write was abandoned on timeout.

Function
REQ-003 All state SHALL update only on rising clk edges where ce=1, except reset; with ce=0 all registers and outputs hold and store_req is ignored.
REQ-004 Buffer SHALL be a FIFO of DEPTH {addr, data} entries with count 0..DEPTH; read and write pointers wrap modulo DEPTH.
REQ-005 Push condition: store_req=1, ce=1 and full=0, sampled before this cycle's pop; the request is then written at the tail on that edge.
REQ-006 store_req=1 while full=1 SHALL drop the request, even if a pop occurs the same cycle, and SHALL set ovf.
REQ-007 A simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-008 FSM states SHALL be IDLE and ISSUE.
REQ-009 IDLE -> ISSUE on the first edge where count>0; the timeout counter clears to 0.
REQ-010 In ISSUE:
- we_mem=1; data_mem and addr_mem equal the FIFO head and are stable for the whole ISSUE interval.
- mem_ready=1 pops the head, drives done=1 for the next cycle, and returns to IDLE.
REQ-011 In ISSUE with mem_ready=0, the timeout counter increments. When it reaches TIMEOUT, the block pops the head, sets err, returns to IDLE and does not pulse done.
REQ-012 There is always one IDLE cycle between consecutive writes.
REQ-013 Minimum latency: store_req at edge N (empty buffer) -> push at edge N, we_mem=1 from edge N+1. With mem_ready=1 in that cycle, done=1 in the cycle after edge N+2.
REQ-014 Outside ISSUE: we_mem=0; data_mem and addr_mem hold their last driven values (0 after reset).
REQ-015 full = (count==DEPTH); busy = (count!=0) or (state!=IDLE).
REQ-016 done is 1 for exactly one ce-qualified cycle per completed write.
REQ-017 ovf and err clear only on reset.

Reset
REQ-018 rst=0 SHALL immediately, without waiting for clk, set: state IDLE; count, pointers and timeout counter 0; data_mem 0; addr_mem 0; we_mem 0; full 0; busy 0; done 0; ovf 0; err 0.
REQ-019 rst asserted mid-ISSUE SHALL abandon the write and discard all buffered entries; no done pulse follows.
REQ-020 After rst returns to 1, the first push is accepted on the next ce-qualified edge.

Verification
REQ-021 Single store: store_req with addr_in=0x05, data_UAL=0x1234, mem_ready=1 -> we_mem=1, addr_mem=0x05, data_mem=0x1234 for one cycle; done pulses once; busy returns to 0.
REQ-022 Overflow: three back-to-back requests (0x0001, 0x0002, 0x0003) with mem_ready=0 -> full=1 after two; third dropped; ovf=1. Then mem_ready=1 -> memory sees only 0x0001 then 0x0002.
REQ-023 Timeout: one request with mem_ready held 0 -> we_mem high for exactly TIMEOUT=15 cycles; err=1; done never pulses; busy=0 afterwards.
REQ-024 ce gating: ce=0 for 5 cycles during ISSUE while mem_ready=1 -> no pop, no done, and the timeout counter frozen. ce=1 -> write completes on the next edge.
REQ-025 Async reset: rst=0 between clock edges during ISSUE with 2 entries buffered -> we_mem, busy and full go 0 immediately; no writes occur after release.
REQ-026 Wrap-around: 6 sequential stores, each completed before the next request -> memory receives all 6 writes in order with correct address/data; pointers wrap without loss.
